// File: rtl/gps_scenario_sched_if.sv
// Bus bundle between the register bank / test driver (master) and gps_scenario_sched (slave).
// Carries table writes, sequence control, the epoch tick and the core configuration outputs.
interface gps_scenario_sched_if #(
  parameter int N_ENTRIES = 4,
  parameter int DWELL_W   = 8
);
  localparam int IDX_W = $clog2(N_ENTRIES);

  logic               wr_en_in;
  logic [IDX_W-1:0]   wr_addr_in;
  logic [4:0]         wr_n_sat_in;
  logic [7:0]         wr_doppler_in;
  logic [15:0]        wr_ca_phase_in;
  logic [7:0]         wr_snr_in;
  logic               wr_noise_off_in;
  logic               wr_signal_off_in;
  logic [DWELL_W-1:0] wr_dwell_in;
  logic [IDX_W-1:0]   last_idx_in;
  logic               go_in;
  logic               abort_in;
  logic               epoch_in;
`ifdef SCHED_LOOP_EN
  logic               loop_in;
`endif
  logic               ena_out;
  logic [4:0]         n_sat_out;
  logic [7:0]         doppler_out;
  logic [15:0]        ca_phase_out;
  logic [7:0]         snr_out;
  logic               noise_off_out;
  logic               signal_off_out;
  logic [IDX_W-1:0]   entry_idx_out;
  logic               busy_out;
  logic               done_out;

  modport master (
    output wr_en_in, wr_addr_in, wr_n_sat_in, wr_doppler_in, wr_ca_phase_in,
           wr_snr_in, wr_noise_off_in, wr_signal_off_in, wr_dwell_in,
           last_idx_in, go_in, abort_in, epoch_in,
`ifdef SCHED_LOOP_EN
           loop_in,
`endif
    input  ena_out, n_sat_out, doppler_out, ca_phase_out, snr_out,
           noise_off_out, signal_off_out, entry_idx_out, busy_out, done_out
  );

  modport slave (
    input  wr_en_in, wr_addr_in, wr_n_sat_in, wr_doppler_in, wr_ca_phase_in,
           wr_snr_in, wr_noise_off_in, wr_signal_off_in, wr_dwell_in,
           last_idx_in, go_in, abort_in, epoch_in,
`ifdef SCHED_LOOP_EN
           loop_in,
`endif
    output ena_out, n_sat_out, doppler_out, ca_phase_out, snr_out,
           noise_off_out, signal_off_out, entry_idx_out, busy_out, done_out
  );
endinterface

// File: rtl/gps_scenario_sched.sv
// Scenario scheduler: steps gps_gen_core through a table of satellite configurations, one per dwell.
// Optional wrap-around looping is enabled by defining SCHED_LOOP_EN.
module gps_scenario_sched #(
  parameter int N_ENTRIES = 4,
  parameter int DWELL_W   = 8
) (
  input logic clk_in,
  input logic rst_in_n,
  gps_scenario_sched_if.slave bus
);
  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(N_ENTRIES - 1);

  typedef struct packed {
    logic [4:0]  n_sat;
    logic [7:0]  doppler;
    logic [15:0] ca_phase;
    logic [7:0]  snr;
    logic        noise_off;
    logic        signal_off;
  } cfg_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  cfg_t               tbl_cfg   [N_ENTRIES];
  logic [DWELL_W-1:0] tbl_dwell [N_ENTRIES];

  state_t             state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [DWELL_W-1:0] cnt_reg;
  logic               ena_reg;
  logic               busy_reg;
  logic               done_reg;
  cfg_t               cfg_reg;

  // Out-of-range write addresses match no entry and are dropped.
  for (genvar gi = 0; gi < N_ENTRIES; gi++) begin : g_tbl
    cfg_t               cfg_q;
    logic [DWELL_W-1:0] dwell_q;

    always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
        cfg_q   <= '0;
        dwell_q <= '0;
      end else if (bus.wr_en_in && (bus.wr_addr_in == IDX_W'(gi))) begin
        cfg_q   <= '{n_sat:      bus.wr_n_sat_in,
                     doppler:    bus.wr_doppler_in,
                     ca_phase:   bus.wr_ca_phase_in,
                     snr:        bus.wr_snr_in,
                     noise_off:  bus.wr_noise_off_in,
                     signal_off: bus.wr_signal_off_in};
        dwell_q <= bus.wr_dwell_in;
      end
    end

    assign tbl_cfg[gi]   = cfg_q;
    assign tbl_dwell[gi] = dwell_q;
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      ena_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      cfg_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      if (bus.abort_in) begin
        state_reg <= S_IDLE;
        idx_reg   <= '0;
        ena_reg   <= 1'b0;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (bus.go_in) begin
              state_reg <= S_LOAD;
              idx_reg   <= '0;
              busy_reg  <= 1'b1;
            end
          end
          S_LOAD: begin
            // Table read sees pre-write contents, so a same-cycle write lands after this load.
            cfg_reg   <= tbl_cfg[idx_reg];
            cnt_reg   <= (tbl_dwell[idx_reg] == '0) ? DWELL_W'(1) : tbl_dwell[idx_reg];
            ena_reg   <= 1'b1;
            state_reg <= S_RUN;
          end
          S_RUN: begin
            if (bus.epoch_in) begin
              if (cnt_reg > DWELL_W'(1)) begin
                cnt_reg <= cnt_reg - DWELL_W'(1);
              end else if ((idx_reg < bus.last_idx_in) && (idx_reg < MAX_IDX)) begin
                idx_reg   <= idx_reg + IDX_W'(1);
                ena_reg   <= 1'b0;
                state_reg <= S_LOAD;
`ifdef SCHED_LOOP_EN
              end else if (bus.loop_in) begin
                idx_reg   <= '0;
                ena_reg   <= 1'b0;
                state_reg <= S_LOAD;
`endif
              end else begin
                ena_reg   <= 1'b0;
                done_reg  <= 1'b1;
                busy_reg  <= 1'b0;
                state_reg <= S_IDLE;
              end
            end
          end
          default: begin
            state_reg <= S_IDLE;
            ena_reg   <= 1'b0;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ena_out        = ena_reg;
  assign bus.n_sat_out      = cfg_reg.n_sat;
  assign bus.doppler_out    = cfg_reg.doppler;
  assign bus.ca_phase_out   = cfg_reg.ca_phase;
  assign bus.snr_out        = cfg_reg.snr;
  assign bus.noise_off_out  = cfg_reg.noise_off;
  assign bus.signal_off_out = cfg_reg.signal_off;
  assign bus.entry_idx_out  = idx_reg;
  assign bus.busy_out       = busy_reg;
  assign bus.done_out       = done_reg;
endmodule

// File: tb/tb_gps_scenario_sched.sv
// Directed bench for gps_scenario_sched: sequencing, dwell-0, abort, write collision, reset
// and (with SCHED_LOOP_EN) looping.
module tb_gps_scenario_sched;
  logic clk_in = 1'b0;
  logic rst_in_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk_in = ~clk_in;

  gps_scenario_sched_if #(.N_ENTRIES(4), .DWELL_W(8)) bus ();

  gps_scenario_sched #(.N_ENTRIES(4), .DWELL_W(8)) dut (
    .clk_in   (clk_in),
    .rst_in_n (rst_in_n),
    .bus      (bus.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic write_entry(input logic [1:0] addr, input logic [4:0] nsat,
                             input logic [7:0] dop, input logic [7:0] dwell);
    bus.wr_en_in         = 1'b1;
    bus.wr_addr_in       = addr;
    bus.wr_n_sat_in      = nsat;
    bus.wr_doppler_in    = dop;
    bus.wr_ca_phase_in   = {8'hA5, 3'b0, nsat};
    bus.wr_snr_in        = dop ^ 8'hFF;
    bus.wr_noise_off_in  = nsat[0];
    bus.wr_signal_off_in = nsat[1];
    bus.wr_dwell_in      = dwell;
    tick();
    bus.wr_en_in = 1'b0;
  endtask

  task automatic pulse_go();
    bus.go_in = 1'b1;
    tick();
    bus.go_in = 1'b0;
  endtask

  task automatic pulse_epoch();
    bus.epoch_in = 1'b1;
    tick();
    bus.epoch_in = 1'b0;
  endtask

  initial begin
    bus.wr_en_in = 1'b0; bus.wr_addr_in = '0; bus.wr_n_sat_in = '0; bus.wr_doppler_in = '0;
    bus.wr_ca_phase_in = '0; bus.wr_snr_in = '0; bus.wr_noise_off_in = 1'b0;
    bus.wr_signal_off_in = 1'b0; bus.wr_dwell_in = '0; bus.last_idx_in = '0;
    bus.go_in = 1'b0; bus.abort_in = 1'b0; bus.epoch_in = 1'b0;
`ifdef SCHED_LOOP_EN
    bus.loop_in = 1'b0;
`endif
    tick(); tick();
    rst_in_n = 1'b1;
    tick();
    check_eq("rst_ena", bus.ena_out, 0);
    check_eq("rst_busy", bus.busy_out, 0);
    check_eq("rst_done", bus.done_out, 0);
    check_eq("rst_nsat", bus.n_sat_out, 0);
    check_eq("rst_idx", bus.entry_idx_out, 0);

    // Two entries: dwell 3 (n_sat 5), dwell 2 (n_sat 12)
    write_entry(2'd0, 5'd5, 8'h11, 8'd3);
    write_entry(2'd1, 5'd12, 8'h22, 8'd2);
    bus.last_idx_in = 2'd1;
    pulse_go();
    check_eq("seq_load_busy", bus.busy_out, 1);
    check_eq("seq_load_ena", bus.ena_out, 0);
    tick();
    check_eq("seq_e0_ena", bus.ena_out, 1);
    check_eq("seq_e0_nsat", bus.n_sat_out, 5);
    check_eq("seq_e0_dop", bus.doppler_out, 8'h11);
    check_eq("seq_e0_phase", bus.ca_phase_out, 16'hA505);
    check_eq("seq_e0_snr", bus.snr_out, 8'hEE);
    check_eq("seq_e0_noff", bus.noise_off_out, 1);
    pulse_epoch();
    tick();
    check_eq("seq_ep1_ena", bus.ena_out, 1);
    pulse_epoch();
    check_eq("seq_ep2_ena", bus.ena_out, 1);
    check_eq("seq_ep2_nsat", bus.n_sat_out, 5);
    pulse_epoch();
    check_eq("seq_gap_ena", bus.ena_out, 0);
    check_eq("seq_gap_busy", bus.busy_out, 1);
    check_eq("seq_gap_idx", bus.entry_idx_out, 1);
    tick();
    check_eq("seq_e1_ena", bus.ena_out, 1);
    check_eq("seq_e1_nsat", bus.n_sat_out, 12);
    check_eq("seq_e1_soff", bus.signal_off_out, 0);
    pulse_epoch();
    check_eq("seq_e1_ep1_ena", bus.ena_out, 1);
    check_eq("seq_e1_ep1_done", bus.done_out, 0);
    pulse_epoch();
    check_eq("seq_end_done", bus.done_out, 1);
    check_eq("seq_end_ena", bus.ena_out, 0);
    check_eq("seq_end_busy", bus.busy_out, 0);
    tick();
    check_eq("seq_post_done", bus.done_out, 0);
    check_eq("seq_post_ena", bus.ena_out, 0);
    check_eq("seq_hold_nsat", bus.n_sat_out, 12);

    // Dwell 0 acts as dwell 1
    write_entry(2'd0, 5'd7, 8'h33, 8'd0);
    bus.last_idx_in = 2'd0;
    pulse_go();
    tick();
    check_eq("d0_ena", bus.ena_out, 1);
    check_eq("d0_nsat", bus.n_sat_out, 7);
    pulse_epoch();
    check_eq("d0_done", bus.done_out, 1);
    check_eq("d0_ena_off", bus.ena_out, 0);

    // Abort during second epoch of entry 1
    write_entry(2'd0, 5'd5, 8'h11, 8'd1);
    write_entry(2'd1, 5'd12, 8'h22, 8'd3);
    bus.last_idx_in = 2'd1;
    pulse_go();
    tick();
    pulse_epoch();
    tick();
    check_eq("ab_e1_nsat", bus.n_sat_out, 12);
    pulse_epoch();
    bus.abort_in = 1'b1;
    pulse_epoch();
    bus.abort_in = 1'b0;
    check_eq("ab_ena", bus.ena_out, 0);
    check_eq("ab_done", bus.done_out, 0);
    check_eq("ab_idx", bus.entry_idx_out, 0);
    check_eq("ab_busy", bus.busy_out, 0);
    pulse_epoch();
    check_eq("ab_late_done", bus.done_out, 0);
    bus.abort_in = 1'b1;
    pulse_go();
    bus.abort_in = 1'b0;
    check_eq("ab_go_busy", bus.busy_out, 0);
    pulse_go();
    tick();
    check_eq("ab_restart_idx", bus.entry_idx_out, 0);
    check_eq("ab_restart_nsat", bus.n_sat_out, 5);
    check_eq("ab_restart_ena", bus.ena_out, 1);
    bus.abort_in = 1'b1;
    tick();
    bus.abort_in = 1'b0;

    // Write to entry 1 in the cycle it is loaded
    write_entry(2'd0, 5'd3, 8'h44, 8'd1);
    write_entry(2'd1, 5'd12, 8'h22, 8'd1);
    pulse_go();
    tick();
    pulse_epoch();
    write_entry(2'd1, 5'd20, 8'h55, 8'd1);
    check_eq("rbw_nsat_old", bus.n_sat_out, 12);
    check_eq("rbw_dop_old", bus.doppler_out, 8'h22);
    pulse_epoch();
    check_eq("rbw_done", bus.done_out, 1);
    pulse_go();
    tick();
    pulse_epoch();
    tick();
    check_eq("rbw_nsat_new", bus.n_sat_out, 20);
    pulse_epoch();

`ifdef SCHED_LOOP_EN
    write_entry(2'd0, 5'd1, 8'h01, 8'd1);
    write_entry(2'd1, 5'd2, 8'h02, 8'd1);
    bus.loop_in = 1'b1;
    pulse_go();
    tick();
    check_eq("lp_idx0", bus.entry_idx_out, 0);
    pulse_epoch();
    check_eq("lp_gap1_ena", bus.ena_out, 0);
    tick();
    check_eq("lp_idx1", bus.entry_idx_out, 1);
    pulse_epoch();
    check_eq("lp_wrap_ena", bus.ena_out, 0);
    check_eq("lp_wrap_done", bus.done_out, 0);
    tick();
    check_eq("lp_wrap_idx", bus.entry_idx_out, 0);
    check_eq("lp_wrap_nsat", bus.n_sat_out, 1);
    pulse_epoch();
    tick();
    bus.loop_in = 1'b0;
    pulse_epoch();
    check_eq("lp_end_done", bus.done_out, 1);
    check_eq("lp_end_ena", bus.ena_out, 0);
`endif

    // Asynchronous reset mid-RUN
    write_entry(2'd0, 5'd9, 8'h66, 8'd4);
    bus.last_idx_in = 2'd0;
    pulse_go();
    tick();
    check_eq("ar_pre_ena", bus.ena_out, 1);
    #2 rst_in_n = 1'b0;
    #1;
    check_eq("ar_ena", bus.ena_out, 0);
    check_eq("ar_nsat", bus.n_sat_out, 0);
    check_eq("ar_busy", bus.busy_out, 0);
    tick();
    rst_in_n = 1'b1;
    tick();
    check_eq("ar_post_busy", bus.busy_out, 0);
    check_eq("ar_post_idx", bus.entry_idx_out, 0);
    pulse_go();
    tick();
    check_eq("ar_tbl_clear", bus.n_sat_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
